// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types for the basic circuit library: skid stage state encoding.
// Optional flush on the skid stage is controlled by ZION_SKID_STAGE_FLUSH_EN.
package zion_basic_circuit_lib_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/zion_basic_circuit_lib_en_rc_dff.sv
// Enabled register with configurable reset style (sync/async, polarity) and reset value.
module zion_basic_circuit_lib_en_rc_dff #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter bit               RST_SYN  = 1'b0,
    parameter bit               RST_POS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (!RST_SYN && RST_POS) begin : g_async_pos
            // NOTE: data registers are reset here so oDat reads INI_DATA right after reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= INI_DATA;
                else if (en) q <= d;
            end
        end else if (!RST_SYN) begin : g_async_neg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)    q <= INI_DATA;
                else if (en) q <= d;
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (rst == RST_POS) q <= INI_DATA;
                else if (en)        q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/zion_basic_circuit_lib_skid_stage.sv
// Two-entry skid buffer with registered valid/ready; iClr flush exists only
// when ZION_SKID_STAGE_FLUSH_EN is defined.
module zion_basic_circuit_lib_skid_stage
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
`ifdef ZION_SKID_STAGE_FLUSH_EN
    ,
    input  logic             iClr
`endif
);

    skid_state_t      state, state_nxt;
    logic             up_xfer, dn_xfer;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, skid_q;

    assign up_xfer = iVld & oRdy;
    assign dn_xfer = oVld & iRdy;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = iDat;
        case (state)
            EMPTY: begin
                if (up_xfer) begin
                    main_en   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (up_xfer && dn_xfer) begin
                    main_en = 1'b1;
                end else if (up_xfer) begin
                    skid_en   = 1'b1;
                    state_nxt = TWO;
                end else if (dn_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                main_d = skid_q;
                if (dn_xfer) begin
                    main_en   = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
`ifdef ZION_SKID_STAGE_FLUSH_EN
        // Flush wins over everything: drop the held words and any incoming one.
        if (iClr) begin
            state_nxt = EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
`endif
    end

    // Handshake outputs get their own flops so neither depends on combinational decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            oVld  <= 1'b0;
            oRdy  <= 1'b1;
        end else begin
            state <= state_nxt;
            oVld  <= (state_nxt != EMPTY);
            oRdy  <= (state_nxt != TWO);
        end
    end

    zion_basic_circuit_lib_en_rc_dff #(
        .WIDTH   (WIDTH),
        .INI_DATA(INI_DATA),
        .RST_SYN (1'b0),
        .RST_POS (1'b1)
    ) u_main_reg (
        .clk(clk),
        .rst(rst),
        .en (main_en),
        .d  (main_d),
        .q  (oDat)
    );

    zion_basic_circuit_lib_en_rc_dff #(
        .WIDTH   (WIDTH),
        .INI_DATA(INI_DATA),
        .RST_SYN (1'b0),
        .RST_POS (1'b1)
    ) u_skid_reg (
        .clk(clk),
        .rst(rst),
        .en (skid_en),
        .d  (iDat),
        .q  (skid_q)
    );

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_stage.sv
// Directed and randomized bench for the skid stage; flush test runs only when
// ZION_SKID_STAGE_FLUSH_EN is defined.
module tb_zion_basic_circuit_lib_skid_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       iVld;
    logic       oRdy;
    logic [7:0] iDat;
    logic       oVld;
    logic       iRdy;
    logic [7:0] oDat;
`ifdef ZION_SKID_STAGE_FLUSH_EN
    logic       iClr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zion_basic_circuit_lib_skid_stage #(
        .WIDTH   (8),
        .INI_DATA(8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iVld(iVld),
        .oRdy(oRdy),
        .iDat(iDat),
        .oVld(oVld),
        .iRdy(iRdy),
        .oDat(oDat)
`ifdef ZION_SKID_STAGE_FLUSH_EN
        ,
        .iClr(iClr)
`endif
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic vld, input logic rdy,
                              input logic [7:0] dat, input logic chk_dat);
        total++;
        if (oVld !== vld) begin
            bad++;
            $display("FAIL %s.oVld got=%b want=%b", name, oVld, vld);
        end
        total++;
        if (oRdy !== rdy) begin
            bad++;
            $display("FAIL %s.oRdy got=%b want=%b", name, oRdy, rdy);
        end
        if (chk_dat) begin
            total++;
            if (oDat !== dat) begin
                bad++;
                $display("FAIL %s.oDat got=%h want=%h", name, oDat, dat);
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        iVld = 1'b0;
        iRdy = 1'b0;
        iDat = 8'h00;
        step();
        step();
        expect_out("reset", 1'b0, 1'b1, 8'h00, 1'b1);
        rst = 1'b0;
        step();
        expect_out("reset_release", 1'b0, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_single();
        iRdy = 1'b1;
        iVld = 1'b1;
        iDat = 8'h11;
        step();
        expect_out("single_first", 1'b1, 1'b1, 8'h11, 1'b1);
        iVld = 1'b0;
        step();
        // oDat keeps the last main value even after going empty
        expect_out("single_drained", 1'b0, 1'b1, 8'h11, 1'b1);
    endtask

    task automatic test_back_to_back();
        iRdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            iVld = 1'b1;
            iDat = 8'(i);
            step();
            expect_out($sformatf("stream_%0d", i), 1'b1, 1'b1, 8'(i), 1'b1);
        end
        iVld = 1'b0;
        step();
        expect_out("stream_end", 1'b0, 1'b1, 8'h10, 1'b1);
    endtask

    task automatic test_backpressure();
        iRdy = 1'b0;
        iVld = 1'b1;
        iDat = 8'hA1;
        step();
        expect_out("bp_one", 1'b1, 1'b1, 8'hA1, 1'b1);
        iDat = 8'hA2;
        step();
        expect_out("bp_two", 1'b1, 1'b0, 8'hA1, 1'b1);
        iDat = 8'hEE;
        step();
        expect_out("bp_stall", 1'b1, 1'b0, 8'hA1, 1'b1);
        iVld = 1'b0;
        iRdy = 1'b1;
        step();
        expect_out("bp_drain1", 1'b1, 1'b1, 8'hA2, 1'b1);
        step();
        expect_out("bp_drain2", 1'b0, 1'b1, 8'hA2, 1'b1);
    endtask

    task automatic test_mid_reset();
        iRdy = 1'b0;
        iVld = 1'b1;
        iDat = 8'hB1;
        step();
        iDat = 8'hB2;
        step();
        expect_out("mr_full", 1'b1, 1'b0, 8'hB1, 1'b1);
        iVld = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_out("mr_async", 1'b0, 1'b1, 8'h00, 1'b1);
        #1 rst = 1'b0;
        step();
        iVld = 1'b1;
        iRdy = 1'b1;
        iDat = 8'hC3;
        step();
        expect_out("mr_after", 1'b1, 1'b1, 8'hC3, 1'b1);
        iVld = 1'b0;
        step();
        expect_out("mr_empty", 1'b0, 1'b1, 8'hC3, 1'b1);
    endtask

`ifdef ZION_SKID_STAGE_FLUSH_EN
    task automatic test_flush();
        iClr = 1'b0;
        iRdy = 1'b0;
        iVld = 1'b1;
        iDat = 8'hF1;
        step();
        iDat = 8'hF2;
        step();
        expect_out("fl_full", 1'b1, 1'b0, 8'hF1, 1'b1);
        iClr = 1'b1;
        iDat = 8'hDD;
        step();
        expect_out("fl_clear", 1'b0, 1'b1, 8'hF1, 1'b1);
        iClr = 1'b0;
        iVld = 1'b0;
        step();
        expect_out("fl_hold", 1'b0, 1'b1, 8'hF1, 1'b1);
        iVld = 1'b1;
        iRdy = 1'b1;
        iDat = 8'h5A;
        step();
        expect_out("fl_next", 1'b1, 1'b1, 8'h5A, 1'b1);
        iVld = 1'b0;
        step();
        expect_out("fl_end", 1'b0, 1'b1, 8'h5A, 1'b1);
    endtask
`endif

    task automatic test_random();
        logic [7:0] q[$];
        logic       up;
        logic       dn;
        int         errs_before;
        rst  = 1'b1;
        iVld = 1'b0;
        iRdy = 1'b0;
        #2 rst = 1'b0;
        step();
        errs_before = bad;
        for (int c = 0; c < 10000; c++) begin
            // Outputs must follow the queue model; head word must be presented.
            expect_out($sformatf("rnd_%0d", c), (q.size() > 0), (q.size() < 2),
                       (q.size() > 0) ? q[0] : 8'h00, (q.size() > 0));
            if (bad - errs_before > 10) begin
                $display("FAIL rnd_abort got=%0d errors want=0", bad - errs_before);
                break;
            end
            iVld = 1'($urandom_range(0, 1));
            iRdy = 1'($urandom_range(0, 1));
            iDat = 8'($urandom);
            up   = iVld && (q.size() < 2);
            dn   = iRdy && (q.size() > 0);
            if (dn) void'(q.pop_front());
            if (up) q.push_back(iDat);
            step();
        end
        iVld = 1'b0;
        iRdy = 1'b1;
        step();
        step();
        expect_out("rnd_drained", 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
`ifdef ZION_SKID_STAGE_FLUSH_EN
        iClr = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
`ifdef ZION_SKID_STAGE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zion_basic_circuit_lib_skid_stage.md
ZION_BASIC_CIRCUIT_LIB_SKID_STAGE -- requirements
Module: zion_basic_circuit_lib_skid_stage

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 Parameter INI_DATA, default '0, value loaded into both data registers on reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 iVld  input  1  upstream data valid.
REQ-006 oRdy  output  1  ready to upstream; driven directly from a flop.
REQ-007 iDat  input  WIDTH  upstream payload.
REQ-008 oVld  output  1  downstream data valid; driven directly from a flop.
REQ-009 iRdy  input  1  downstream ready.
REQ-010 oDat  output  WIDTH  downstream payload; driven directly from the main data register.
REQ-011 iClr  input  1  synchronous flush, active-high; present only when ZION_SKID_STAGE_FLUSH_EN is defined.

Function
REQ-012 Upstream transfer = iVld & oRdy; downstream transfer = oVld & iRdy; both evaluated in the same cycle.
REQ-013 State machine SHALL have three states: EMPTY (no data), ONE (main register valid), TWO (main and skid registers valid).
REQ-014 EMPTY: oVld=0, oRdy=1; upstream transfer loads main <= iDat and moves to ONE.
REQ-015 ONE: oVld=1, oRdy=1; simultaneous transfers load main <= iDat and stay in ONE; upstream only loads skid <= iDat and moves to TWO; downstream only moves to EMPTY.
REQ-016 TWO: oVld=1, oRdy=0; downstream transfer loads main <= skid and moves to ONE; iVld ignored.
REQ-017 Latency iDat->oDat is exactly 1 cycle from EMPTY; sustained throughput is one word per cycle while iRdy=1.
REQ-018 Ordering SHALL be strict FIFO; no word duplicated or dropped.
REQ-019 oDat SHALL hold its value while oVld=1 and iRdy=0.
REQ-020 Data registers SHALL load only on the enables in REQ-014..016; all other cycles hold.
REQ-021 oDat value while oVld=0 is don't-care for consumers but SHALL equal the last loaded main value.

Reset
REQ-022 rst asserted: state=EMPTY, oVld=0, oRdy=1, main=skid=INI_DATA, immediately, independent of clk.
REQ-023 rst asserted mid-operation SHALL discard all held words; first transfer after release behaves as from EMPTY.

Configuration
REQ-024 Macro ZION_SKID_STAGE_FLUSH_EN defined: iClr port exists; iClr=1 at a rising edge forces state=EMPTY, oVld=0, oRdy=1 next cycle, data registers hold, any same-cycle upstream transfer is discarded.
REQ-025 Macro undefined: no iClr port, no flush logic; behaviour otherwise identical.

Structure
REQ-026 Shared package zion_basic_circuit_lib_pkg SHALL hold the state enum typedef (EMPTY, ONE, TWO; 2-bit encoding).
REQ-027 Main and skid data registers SHALL each be an instance of sub-module zion_basic_circuit_lib_en_rc_dff (RST_SYN=0, RST_POS=1, INI_DATA passed through); control logic stays in this module.

Verification
REQ-028 Reset, then iVld=1 iDat=0x11 for one cycle with iRdy=1 -> next cycle oVld=1 oDat=0x11; following cycle oVld=0.
REQ-029 iRdy=1 constant, iVld=1 with iDat 0x01..0x10 on consecutive cycles -> oDat 0x01..0x10 on consecutive cycles, oRdy=1 throughout.
REQ-030 iRdy=0, push 0xA1 then 0xA2 -> state TWO, oRdy=0, oDat=0xA1; raise iRdy -> 0xA1 then 0xA2 delivered in order, oRdy returns 1 after first drain.
REQ-031 State TWO (0xB1,0xB2), assert rst for a partial cycle -> oVld=0, oRdy=1, oDat=INI_DATA immediately; after release push 0xC3 -> oDat=0xC3 next cycle.
REQ-032 ZION_SKID_STAGE_FLUSH_EN defined, state TWO, iClr=1 with iVld=1 iDat=0xDD -> next cycle oVld=0, oRdy=1, 0xDD never appears on oDat.
REQ-033 Random iVld/iRdy 10k cycles -> scoreboard shows exact in-order delivery and oDat stable whenever oVld=1 and iRdy=0.
